core_sequencer: RTL and testbench
=================================

# core_sequencer

Parametrised multi-cycle control sequencer for the Hephaestus 16-bit instruction set. It owns the PC and the status register, and steps each instruction through explicit FSM states. Each state drives the register-file, ALU and data-memory control ports. Additions over the current processor control: a synchronous reset, a run/idle gate, a retire strobe and a memory-ready wait handshake.

## Interface
Parameters:
- DATA_W, 8: GPR/ALU/memory data width; must be ≥8.
- PC_W, 8: program counter width.
- REG_AW, 3: GPR index width. Instruction fields are 3 bits, zero-extended to REG_AW.
- MEM_AW, 8: data-memory address width. Fields are zero-extended or truncated to MEM_AW.

Ports:
- clk, in, 1: sole clock; all state updates on its rising edge.
- rst, in, 1: reset, synchronous and active-high.
- run, in, 1: when low, the sequencer idles in FETCH.
- instr, in, 16: instruction-memory word at pc (combinational memory).
- pc, out, PC_W: current PC.
- retire, out, 1: one-cycle pulse in the RETIRE cycle.
- sreg, out, 4: status register {V,S,C,Z}, bits 3..0.
- gpr_rd_en / gpr_wr_en, out, 1: register-file read / write strobes.
- gpr_ra, gpr_rb, gpr_rc, out, REG_AW: read indices A and B, and write index C.
- gpr_wdata, out, DATA_W: write data for the low word.
- gpr_wdata_hi, out, DATA_W: write data for the high product word.
- gpr_rdata_a, gpr_rdata_b, in, DATA_W: register-file read data.
- alu_a, alu_b, out, DATA_W: registered ALU operands.
- alu_fsl, out, 4: ALU function select.
- alu_lo, alu_hi, in, DATA_W: ALU result, low and high words.
- alu_flags, in, 4: ALU flags.
- mem_addr, out, MEM_AW: data-memory address.
- mem_wdata, out, DATA_W: data-memory write data.
- mem_rd, mem_wr, out, 1: data-memory read / write requests.
- mem_rdata, in, DATA_W: data-memory read data.
- mem_ready, in, 1: data-memory completion.

## Operation
Decode:
- Instruction class is instr[15:14].
- 00 ALU: ra=[9:7], rb=[6:4], rc=[3:1], fsl=[13:10].
- 01 Load/store; sub-op in [13:12]:
  - 00 LDI: imm=[10:3], rc=[2:0].
  - 01 LDR: rc=[9:7], ra=[6:4].
  - 10 LDX: rb=[9:7] is the address register, rc=[6:4].
  - 11 ST: addr=[10:3], ra=[2:0].
- 10 Branch: cond=[13:10], target=[9:2].
  - 1000 always taken.
  - 0000..0111: ZS, ZC, CS, CC, SS, SC, VS, VC on sreg bits 0, 0, 1, 1, 2, 2, 3, 3 (set/clear pairs).
  - Any other cond is a no-op.
- 11 MOV: src address [13:7], dst address [6:0].

FSM states:
- FETCH: latch instr into IR when run=1; otherwise stay in FETCH.
- READ: gpr_rd_en=1; capture gpr_rdata_a/b into alu_a/alu_b (LDR also uses the a-capture; LDX/ST use their capture as address or data).
- EXEC: capture alu_lo, alu_hi and alu_flags.
- MEM_RD: mem_rd=1; hold until mem_ready=1, then capture mem_rdata.
- MEM_WR: mem_wr=1; hold until mem_ready=1.
- WRITE: gpr_wr_en=1 with gpr_wdata and gpr_wdata_hi stable.
- RETIRE: retire=1 and pc update.

State paths per class:
- ALU: FETCH→READ→EXEC→WRITE→RETIRE. fsl=1111 (compare) skips the write: gpr_wr_en stays 0 in WRITE.
- LDI: FETCH→WRITE→RETIRE. gpr_wdata = imm zero-extended.
- LDR: FETCH→READ→WRITE→RETIRE.
- LDX: FETCH→READ→MEM_RD→WRITE→RETIRE. mem_addr = the rb data, truncated to MEM_AW.
- ST: FETCH→READ→MEM_WR→RETIRE.
- MOV: FETCH→MEM_RD(src)→MEM_WR(dst)→RETIRE. mem_wdata is the captured read data.
- Branch: FETCH→RETIRE.

RETIRE behaviour:
- pc ← taken ? target : pc+1. target is zero-extended or truncated to PC_W.
- pc wraps from 2^PC_W−1 to 0.
- sreg ← captured flags, for ALU instructions only; all other classes leave sreg unchanged.

## Timing
- Reset values: state=FETCH, pc=0, sreg=0, IR=0, all strobes 0, all data/address outputs 0.
- rst mid-instruction: aborts in the same edge. No further write or memory strobe is issued, and pc is not advanced.
- Strobes are registered. Each is high for exactly one cycle, except mem_rd/mem_wr, which are held through wait states.
- Latency in cycles at zero wait: ALU 5, LDI 3, LDR 4, LDX 5, ST 4, MOV 4, branch 2.
- Each wait cycle (mem_ready=0) adds one cycle. mem_ready=1 in the first request cycle completes with no added cycle.
- mem_ready is ignored outside MEM_RD and MEM_WR.
- run=0 is sampled only in FETCH. An instruction already in flight always completes.
- The branch condition uses sreg as it stands in the RETIRE cycle. A branch immediately after an ALU op therefore sees that op's flags.

## Configuration
- SEQ_MEMWAIT_EN defined: MEM_RD/MEM_WR wait on mem_ready as described.
- SEQ_MEMWAIT_EN undefined: the mem_ready port is still present but ignored. Each memory state lasts exactly one cycle, and read data is captured at the end of that cycle.

## Structure
- Package seq_pkg holds:
  - the state encoding;
  - the class codes;
  - the load/store sub-op codes;
  - the condition codes;
  - FSL_CMP = 4'b1111;
  - the sreg bit positions (Z=0, C=1, S=2, V=3).
- One sub-module, branch_cond_eval: combinational; takes cond and sreg, outputs taken.

## Test plan
- Reset: assert rst in the middle of an LDX wait state → next cycle pc=0, sreg=0, mem_rd=0, and no gpr_wr_en pulse occurs.
- ALU add: r1=3, r2=4, instruction ADD r1,r2→r3 → gpr_wr_en in cycle 4 with wdata=7; retire in cycle 5; pc+1; Z=0.
- Compare: 5 vs 5 with fsl=1111 → no gpr_wr_en; sreg Z=1. A following ZS branch to 0x40 → pc=0x40 two cycles later.
- Memory wait (macro on): LDX with mem_ready low for 3 cycles → mem_rd high for 4 cycles; instruction takes 8 cycles; rc gets mem_rdata.
- Memory wait (macro off): same stimulus → completes in 5 cycles and ignores mem_ready.
- PC wrap and run gating: non-branch instruction at pc=0xFF → pc=0x00. With run=0, pc is frozen, retire stays 0 and there are no strobes.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings for the Hephaestus multi-cycle sequencer: FSM states,
// instruction class/sub-op/condition codes and status-register bit positions.
package seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned SREG_W  = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_READ   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_WRITE  = 3'd5,
    ST_RETIRE = 3'd6
  } state_t;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LS  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_MOV = 2'b11;

  localparam logic [1:0] LS_LDI = 2'b00;
  localparam logic [1:0] LS_LDR = 2'b01;
  localparam logic [1:0] LS_LDX = 2'b10;
  localparam logic [1:0] LS_ST  = 2'b11;

  localparam logic [3:0] COND_ZS     = 4'b0000;
  localparam logic [3:0] COND_ZC     = 4'b0001;
  localparam logic [3:0] COND_CS     = 4'b0010;
  localparam logic [3:0] COND_CC     = 4'b0011;
  localparam logic [3:0] COND_SS     = 4'b0100;
  localparam logic [3:0] COND_SC     = 4'b0101;
  localparam logic [3:0] COND_VS     = 4'b0110;
  localparam logic [3:0] COND_VC     = 4'b0111;
  localparam logic [3:0] COND_ALWAYS = 4'b1000;

  localparam logic [3:0] FSL_CMP = 4'b1111;

  localparam int unsigned SREG_Z = 0;
  localparam int unsigned SREG_C = 1;
  localparam int unsigned SREG_S = 2;
  localparam int unsigned SREG_V = 3;

  // Compare ops run the ALU path but never write the register file.
  function automatic logic isCompare(input logic [INSTR_W-1:0] word);
    return (word[15:14] == CLS_ALU) && (word[13:10] == FSL_CMP);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator over the {V,S,C,Z} status register.
module branch_cond_eval
  import seq_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [SREG_W-1:0] sreg,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ZS:     taken =  sreg[SREG_Z];
      COND_ZC:     taken = ~sreg[SREG_Z];
      COND_CS:     taken =  sreg[SREG_C];
      COND_CC:     taken = ~sreg[SREG_C];
      COND_SS:     taken =  sreg[SREG_S];
      COND_SC:     taken = ~sreg[SREG_S];
      COND_VS:     taken =  sreg[SREG_V];
      COND_VC:     taken = ~sreg[SREG_V];
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: owns PC and sreg, steps each instruction through the FSM.
// Build option SEQ_MEMWAIT_EN: memory states wait on mem_ready; otherwise they last one cycle.
module core_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned MEM_AW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     pc,
  output logic                retire,
  output logic [SREG_W-1:0]   sreg,
  output logic                gpr_rd_en,
  output logic                gpr_wr_en,
  output logic [REG_AW-1:0]   gpr_ra,
  output logic [REG_AW-1:0]   gpr_rb,
  output logic [REG_AW-1:0]   gpr_rc,
  output logic [DATA_W-1:0]   gpr_wdata,
  output logic [DATA_W-1:0]   gpr_wdata_hi,
  input  logic [DATA_W-1:0]   gpr_rdata_a,
  input  logic [DATA_W-1:0]   gpr_rdata_b,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [3:0]          alu_fsl,
  input  logic [DATA_W-1:0]   alu_lo,
  input  logic [DATA_W-1:0]   alu_hi,
  input  logic [SREG_W-1:0]   alu_flags,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_rd,
  output logic                mem_wr,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  state_t              state, stateNext;
  logic [INSTR_W-1:0]  ir, irNext;
  logic [SREG_W-1:0]   flagsQ, flagsNext;
  logic [PC_W-1:0]     pcNext;
  logic [SREG_W-1:0]   sregNext;
  logic                retireNext, rdEnNext, wrEnNext, memRdNext, memWrNext;
  logic [REG_AW-1:0]   raNext, rbNext, rcNext;
  logic [DATA_W-1:0]   wdataNext, wdataHiNext, aluANext, aluBNext, memWdataNext;
  logic [3:0]          fslNext;
  logic [MEM_AW-1:0]   memAddrNext;
  logic                brTaken;
  logic                memGo;
  logic [1:0]          irCls, irSub;

  assign irCls = ir[15:14];
  assign irSub = ir[13:12];

`ifdef SEQ_MEMWAIT_EN
  assign memGo = mem_ready;
`else
  logic unusedMemReady;
  assign memGo = 1'b1;
  assign unusedMemReady = mem_ready;
`endif

  branch_cond_eval uCond (
    .cond  (ir[13:10]),
    .sreg  (sreg),
    .taken (brTaken)
  );

  // Next-state and next-output logic; strobes are derived from the state being entered.
  always_comb begin
    stateNext    = state;
    irNext       = ir;
    flagsNext    = flagsQ;
    pcNext       = pc;
    sregNext     = sreg;
    raNext       = gpr_ra;
    rbNext       = gpr_rb;
    rcNext       = gpr_rc;
    wdataNext    = gpr_wdata;
    wdataHiNext  = gpr_wdata_hi;
    aluANext     = alu_a;
    aluBNext     = alu_b;
    fslNext      = alu_fsl;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;

    case (state)
      ST_FETCH: begin
        if (run) begin
          irNext = instr;
          case (instr[15:14])
            CLS_ALU: begin
              raNext    = REG_AW'(instr[9:7]);
              rbNext    = REG_AW'(instr[6:4]);
              rcNext    = REG_AW'(instr[3:1]);
              fslNext   = instr[13:10];
              stateNext = ST_READ;
            end
            CLS_LS: begin
              case (instr[13:12])
                LS_LDI: begin
                  rcNext    = REG_AW'(instr[2:0]);
                  wdataNext = DATA_W'(instr[10:3]);
                  stateNext = ST_WRITE;
                end
                LS_LDR: begin
                  rcNext    = REG_AW'(instr[9:7]);
                  raNext    = REG_AW'(instr[6:4]);
                  stateNext = ST_READ;
                end
                LS_LDX: begin
                  rbNext    = REG_AW'(instr[9:7]);
                  rcNext    = REG_AW'(instr[6:4]);
                  stateNext = ST_READ;
                end
                default: begin
                  memAddrNext = MEM_AW'(instr[10:3]);
                  raNext      = REG_AW'(instr[2:0]);
                  stateNext   = ST_READ;
                end
              endcase
            end
            CLS_BR:  stateNext = ST_RETIRE;
            default: begin
              memAddrNext = MEM_AW'(instr[13:7]);
              stateNext   = ST_MEM_RD;
            end
          endcase
        end
      end

      ST_READ: begin
        aluANext = gpr_rdata_a;
        aluBNext = gpr_rdata_b;
        if (irCls == CLS_ALU) begin
          stateNext = ST_EXEC;
        end else begin
          case (irSub)
            LS_LDR: begin
              wdataNext = gpr_rdata_a;
              stateNext = ST_WRITE;
            end
            LS_LDX: begin
              memAddrNext = MEM_AW'(gpr_rdata_b);
              stateNext   = ST_MEM_RD;
            end
            LS_ST: begin
              memWdataNext = gpr_rdata_a;
              stateNext    = ST_MEM_WR;
            end
            default: stateNext = ST_RETIRE;
          endcase
        end
      end

      ST_EXEC: begin
        wdataNext   = alu_lo;
        wdataHiNext = alu_hi;
        flagsNext   = alu_flags;
        stateNext   = ST_WRITE;
      end

      ST_MEM_RD: begin
        if (memGo) begin
          if (irCls == CLS_MOV) begin
            memWdataNext = mem_rdata;
            memAddrNext  = MEM_AW'(ir[6:0]);
            stateNext    = ST_MEM_WR;
          end else begin
            wdataNext = mem_rdata;
            stateNext = ST_WRITE;
          end
        end
      end

      ST_MEM_WR: begin
        if (memGo) stateNext = ST_RETIRE;
      end

      ST_WRITE: stateNext = ST_RETIRE;

      ST_RETIRE: begin
        pcNext = (irCls == CLS_BR && brTaken) ? PC_W'(ir[9:2]) : pc + PC_W'(1);
        if (irCls == CLS_ALU) sregNext = flagsQ;
        stateNext = ST_FETCH;
      end

      default: stateNext = ST_FETCH;
    endcase

    rdEnNext   = (stateNext == ST_READ);
    wrEnNext   = (stateNext == ST_WRITE) && !isCompare(irNext);
    memRdNext  = (stateNext == ST_MEM_RD);
    memWrNext  = (stateNext == ST_MEM_WR);
    retireNext = (stateNext == ST_RETIRE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FETCH;
      ir           <= '0;
      flagsQ       <= '0;
      pc           <= '0;
      sreg         <= '0;
      retire       <= 1'b0;
      gpr_rd_en    <= 1'b0;
      gpr_wr_en    <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      gpr_ra       <= '0;
      gpr_rb       <= '0;
      gpr_rc       <= '0;
      gpr_wdata    <= '0;
      gpr_wdata_hi <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_fsl      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state        <= stateNext;
      ir           <= irNext;
      flagsQ       <= flagsNext;
      pc           <= pcNext;
      sreg         <= sregNext;
      retire       <= retireNext;
      gpr_rd_en    <= rdEnNext;
      gpr_wr_en    <= wrEnNext;
      mem_rd       <= memRdNext;
      mem_wr       <= memWrNext;
      gpr_ra       <= raNext;
      gpr_rb       <= rbNext;
      gpr_rc       <= rcNext;
      gpr_wdata    <= wdataNext;
      gpr_wdata_hi <= wdataHiNext;
      alu_a        <= aluANext;
      alu_b        <= aluBNext;
      alu_fsl      <= fslNext;
      mem_addr     <= memAddrNext;
      mem_wdata    <= memWdataNext;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: vector table of instructions with a
// register-write scoreboard, plus reset, run-gating and mid-instruction abort sequences.
module tb_core_sequencer;

`ifdef SEQ_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, run, mem_ready;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        retire;
  logic [3:0]  sreg;
  logic        gpr_rd_en, gpr_wr_en;
  logic [2:0]  gpr_ra, gpr_rb, gpr_rc;
  logic [7:0]  gpr_wdata, gpr_wdata_hi, gpr_rdata_a, gpr_rdata_b;
  logic [7:0]  alu_a, alu_b, alu_lo, alu_hi;
  logic [3:0]  alu_fsl, alu_flags;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;

  core_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .pc(pc), .retire(retire), .sreg(sreg),
    .gpr_rd_en(gpr_rd_en), .gpr_wr_en(gpr_wr_en), .gpr_ra(gpr_ra), .gpr_rb(gpr_rb),
    .gpr_rc(gpr_rc), .gpr_wdata(gpr_wdata), .gpr_wdata_hi(gpr_wdata_hi),
    .gpr_rdata_a(gpr_rdata_a), .gpr_rdata_b(gpr_rdata_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_fsl(alu_fsl), .alu_lo(alu_lo), .alu_hi(alu_hi), .alu_flags(alu_flags),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Environment: instruction memory, register file, data memory, ALU.
  logic [15:0] imem [256];
  logic [7:0]  regs [8];
  logic [7:0]  dmem [256];

  assign instr       = imem[pc];
  assign gpr_rdata_a = regs[gpr_ra];
  assign gpr_rdata_b = regs[gpr_rb];
  assign mem_rdata   = dmem[mem_addr];

  logic [8:0]  sum9, diff9;
  logic [15:0] prod;
  logic        aluC, aluV;
  always_comb begin
    sum9   = {1'b0, alu_a} + {1'b0, alu_b};
    diff9  = {1'b0, alu_a} - {1'b0, alu_b};
    prod   = alu_a * alu_b;
    alu_lo = alu_a ^ alu_b;
    alu_hi = 8'h00;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (alu_fsl)
      4'b0000: begin
        alu_lo = sum9[7:0]; aluC = sum9[8];
        aluV = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
      end
      4'b0001, 4'b1111: begin
        alu_lo = diff9[7:0]; aluC = diff9[8];
        aluV = (alu_a[7] != alu_b[7]) && (diff9[7] != alu_a[7]);
      end
      4'b0101: begin
        alu_lo = prod[7:0]; alu_hi = prod[15:8]; aluC = (prod[15:8] != 8'h00);
      end
      default: ;
    endcase
    alu_flags = {aluV, alu_lo[7], aluC, (alu_lo == 8'h00)};
  end

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [2:0] rc;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       hiChk;
  } wr_t;
  wr_t sbQ[$];

  typedef struct {
    string       name;
    logic [15:0] word;
    int          waits;
    int          cyc;
    int          memCyc;
    bit          wr;
    logic [2:0]  rc;
    logic [7:0]  lo;
    logic [7:0]  hi;
    bit          hiChk;
    logic [7:0]  pcAfter;
    logic [3:0]  sregAfter;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [15:0] w, input int waits,
                              input int cyc, input int memCyc, input bit wr,
                              input logic [2:0] rc, input logic [7:0] lo, input logic [7:0] hi,
                              input bit hiChk, input logic [7:0] pcA, input logic [3:0] sr);
    vec_t v;
    v.name = n; v.word = w; v.waits = waits; v.cyc = cyc; v.memCyc = memCyc; v.wr = wr;
    v.rc = rc; v.lo = lo; v.hi = hi; v.hiChk = hiChk; v.pcAfter = pcA; v.sregAfter = sr;
    return v;
  endfunction

  vec_t vecs [17];

  // Runs one instruction from an idle FETCH and checks latency, strobes, writes, pc and sreg.
  task automatic runVec(input vec_t v, input logic [7:0] atPc);
    int  cycles, memCyc, wrCount, wrCyc, waitLeft, expCyc;
    bit  done;
    wr_t e;
    imem[atPc] = v.word;
    if (v.wr) begin
      e.rc = v.rc; e.lo = v.lo; e.hi = v.hi; e.hiChk = v.hiChk;
      sbQ.push_back(e);
    end
    waitLeft = v.waits;
    memCyc = 0; wrCount = 0; wrCyc = 0; done = 1'b0;
    expCyc = v.cyc + (MEMWAIT ? v.waits : 0);
    @(negedge clk); run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    cycles = 1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cycles++;
      if (mem_rd || mem_wr) begin
        memCyc++;
        if (waitLeft > 0) begin
          mem_ready = 1'b0;
          waitLeft--;
        end else begin
          mem_ready = 1'b1;
        end
        if (mem_wr) dmem[mem_addr] = mem_wdata;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (gpr_wr_en) begin
        wrCount++;
        wrCyc = cycles;
        regs[gpr_rc] = gpr_wdata;
        check({v.name, " write expected"}, 32'(sbQ.size() != 0), 1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          check({v.name, " wr index"}, gpr_rc, e.rc);
          check({v.name, " wr data"}, gpr_wdata, e.lo);
          if (e.hiChk) check({v.name, " wr data hi"}, gpr_wdata_hi, e.hi);
        end
      end
      if (retire) done = 1'b1;
    end
    check({v.name, " retire seen"}, done, 1);
    check({v.name, " latency"}, cycles, expCyc);
    check({v.name, " mem cycles"}, memCyc,
          v.memCyc + ((MEMWAIT && v.memCyc > 0) ? v.waits : 0));
    check({v.name, " write count"}, wrCount, v.wr);
    if (v.wr) check({v.name, " write cycle"}, wrCyc, expCyc - 1);
    @(posedge clk); #1;
    check({v.name, " pc"}, pc, v.pcAfter);
    check({v.name, " sreg"}, sreg, v.sregAfter);
    check({v.name, " retire one cycle"}, retire, 0);
  endtask

  initial begin
    int         cnt;
    bit         found;
    logic [7:0] curPc;

    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 8'h00;
    end
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    regs[1] = 8'h03; regs[2] = 8'h04; regs[4] = 8'h10; regs[5] = 8'h05; regs[6] = 8'h05;
    dmem[8'h10] = 8'hA5;
    dmem[8'h20] = 8'h3C;

    //          name        word      wt cyc mem wr rc    lo     hi     hc pcAfter sreg
    vecs[0]  = mk("add",     16'h00A6, 0, 5, 0, 1, 3'd3, 8'h07, 8'h00, 1, 8'h01, 4'h0);
    vecs[1]  = mk("cmp",     16'h3EEE, 0, 5, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h02, 4'h1);
    vecs[2]  = mk("br_zs",   16'h8100, 0, 2, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h40, 4'h1);
    vecs[3]  = mk("ldi",     16'h42D2, 0, 3, 0, 1, 3'd2, 8'h5A, 8'h00, 0, 8'h41, 4'h1);
    vecs[4]  = mk("ldr",     16'h5390, 0, 4, 0, 1, 3'd7, 8'h03, 8'h00, 0, 8'h42, 4'h1);
    vecs[5]  = mk("ldx",     16'h6260, 3, 5, 1, 1, 3'd6, 8'hA5, 8'h00, 0, 8'h43, 4'h1);
    vecs[6]  = mk("st",      16'h7183, 1, 4, 1, 0, 3'd0, 8'h00, 8'h00, 0, 8'h44, 4'h1);
    vecs[7]  = mk("mov",     16'hD031, 0, 4, 2, 0, 3'd0, 8'h00, 8'h00, 0, 8'h45, 4'h1);
    vecs[8]  = mk("br_zc",   16'h8440, 0, 2, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h46, 4'h1);
    vecs[9]  = mk("sub",     16'h04A0, 0, 5, 0, 1, 3'd0, 8'hA9, 8'h00, 1, 8'h47, 4'h6);
    vecs[10] = mk("br_cs",   16'h8A00, 0, 2, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h80, 4'h6);
    vecs[11] = mk("br_vs",   16'h9800, 0, 2, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h81, 4'h6);
    vecs[12] = mk("br_nop",  16'hA400, 0, 2, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h82, 4'h6);
    vecs[13] = mk("br_al",   16'hA3FC, 0, 2, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'hFF, 4'h6);
    vecs[14] = mk("ldi_wrap",16'h4009, 0, 3, 0, 1, 3'd1, 8'h01, 8'h00, 0, 8'h00, 4'h6);
    vecs[15] = mk("mul",     16'h17EA, 0, 5, 0, 1, 3'd5, 8'hEF, 8'h01, 1, 8'h01, 4'h6);
    vecs[16] = mk("br_33",   16'hA0CC, 0, 2, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h33, 4'h6);

    // Reset state
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pc", pc, 0);
    check("reset sreg", sreg, 0);
    check("reset strobes", {retire, gpr_rd_en, gpr_wr_en, mem_rd, mem_wr}, 0);
    check("reset data outs", {alu_a, alu_b, gpr_wdata, mem_addr, mem_wdata}, 0);
    @(negedge clk); rst = 1'b0;

    // Idle with run low: pc frozen, no strobes
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(retire | gpr_rd_en | gpr_wr_en | mem_rd | mem_wr);
    end
    check("idle strobes", cnt, 0);
    check("idle pc", pc, 0);

    curPc = 8'h00;
    for (int i = 0; i < 17; i++) begin
      runVec(vecs[i], curPc);
      curPc = vecs[i].pcAfter;
    end
    check("st stored", dmem[8'h30], 8'h07);
    check("mov stored", dmem[8'h31], 8'h3C);

    // Reset during an LDX memory read aborts it
    imem[8'h33] = 16'h6260;
    @(negedge clk); run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_rd) found = 1'b1;
    end
    check("abort reached mem_rd", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort pc", pc, 0);
    check("abort sreg", sreg, 0);
    check("abort mem_rd", mem_rd, 0);
    check("abort wr_en", gpr_wr_en, 0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(retire | gpr_rd_en | gpr_wr_en | mem_rd | mem_wr);
    end
    check("post-abort strobes", cnt, 0);
    check("post-abort pc", pc, 0);
    check("scoreboard drained", sbQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
